// File: rtl/sprite_pkg.sv
// Shared types for the sprite command sequencer: descriptor layout, register map, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

    // One queued draw request; field order sets the packed layout (id is the MSBs).
    typedef struct packed {
        logic [15:0] id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] addr;
        logic [7:0]  rot;
    } sprite_desc_t;

    // Word register offsets on the Avalon-MM slave.
    localparam logic [3:0] REG_ID     = 4'd0;
    localparam logic [3:0] REG_X      = 4'd1;
    localparam logic [3:0] REG_Y      = 4'd2;
    localparam logic [3:0] REG_W      = 4'd3;
    localparam logic [3:0] REG_H      = 4'd4;
    localparam logic [3:0] REG_ADDR   = 4'd5;
    localparam logic [3:0] REG_ROT    = 4'd6;
    localparam logic [3:0] REG_PUSH   = 4'd7;
    localparam logic [3:0] REG_STATUS = 4'd8;
    localparam logic [3:0] REG_CTRL   = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_RELEASE
    } seq_state_t;

endpackage

// File: rtl/sprite_desc_fifo.sv
// Synchronous FIFO of sprite descriptors with flush; head is always visible on head_dat_o.
// Latency: a push is visible at the head one cycle later; count updates on the same edge.
// Backpressure: push while full is dropped unless a pop happens that cycle; flush beats push and pop.
module sprite_desc_fifo
    import sprite_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  sprite_desc_t                 push_dat_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output sprite_desc_t                 head_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    sprite_desc_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_pop;
    logic           do_push;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sprite_cmd_sequencer.sv
// CPU-facing descriptor queue that issues sprites to the drawer one at a time via draw_sprite/done_draw.
// Latency: readdata 1 cycle; a queued sprite is issued 1 cycle after it reaches an idle head.
// Backpressure: pushes into a full queue are dropped and flagged; a hung drawer is aborted after TIMEOUT_CYC.
module sprite_cmd_sequencer
    import sprite_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        draw_sprite,
    input  logic        done_draw,
    output logic [15:0] sprite_id,
    output logic [15:0] sprite_x,
    output logic [15:0] sprite_y,
    output logic [15:0] sprite_width,
    output logic [15:0] sprite_height,
    output logic [31:0] sprite_address,
    output logic [7:0]  sprite_rotate,
    output logic        seq_idle
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    sprite_desc_t   stage_q;
    sprite_desc_t   out_q;
    sprite_desc_t   fifo_head;
    seq_state_t     state_q;
    seq_state_t     state_d;
    logic [TW-1:0]  tmo_cnt_q;
    logic           rel_cnt_q;
    logic           owned_q;
    logic           ovf_q;
    logic           tmo_q;
    logic           draw_q;
    logic           seq_idle_q;
    logic [31:0]    rdata_q;
    logic [31:0]    status;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [CW-1:0]  fifo_count;
    logic           wr_push;
    logic           wr_ctrl;
    logic           flush;
    logic           issue;
    logic           finish;
    logic           tmo_hit;
    logic           tmo_expired;

    assign wr_push     = avs_write && (avs_address == REG_PUSH);
    assign wr_ctrl     = avs_write && (avs_address == REG_CTRL);
    assign flush       = wr_ctrl && avs_writedata[0];
    assign tmo_expired = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    // Only pop the entry we issued; a flush mid-draw already removed it.
    assign fifo_pop    = finish && owned_q && !fifo_empty;

    sprite_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (Clk),
        .reset_i    (Reset),
        .push_i     (wr_push),
        .push_dat_i (stage_q),
        .pop_i      (fifo_pop),
        .flush_i    (flush),
        .head_dat_o (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // Staging registers: CPU writes fields one at a time before PUSH.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stage_q <= '0;
        end else if (avs_write) begin
            case (avs_address)
                REG_ID:   stage_q.id   <= avs_writedata[15:0];
                REG_X:    stage_q.x    <= avs_writedata[15:0];
                REG_Y:    stage_q.y    <= avs_writedata[15:0];
                REG_W:    stage_q.w    <= avs_writedata[15:0];
                REG_H:    stage_q.h    <= avs_writedata[15:0];
                REG_ADDR: stage_q.addr <= avs_writedata;
                REG_ROT:  stage_q.rot  <= avs_writedata[7:0];
                default:  stage_q      <= stage_q;
            endcase
        end
    end

    // Next-state logic; ISSUE waits for the drawer to drop done_draw so a stale high is not completion.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        finish  = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    issue   = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    finish  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (!done_draw) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tmo_expired) begin
                    tmo_hit = 1'b1;
                    finish  = 1'b1;
                    state_d = ST_RELEASE;
                end else if (done_draw) begin
                    finish  = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Timeout/release counters, sticky flags and the held output descriptor.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tmo_cnt_q  <= '0;
            rel_cnt_q  <= 1'b0;
            owned_q    <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            draw_q     <= 1'b0;
            out_q      <= '0;
            seq_idle_q <= 1'b1;
        end else begin
            tmo_cnt_q <= (state_q == ST_ISSUE || state_q == ST_BUSY) ? tmo_cnt_q + TW'(1) : '0;
            rel_cnt_q <= (state_q == ST_RELEASE) ? ~rel_cnt_q : 1'b0;
            if (issue) begin
                owned_q <= !flush;
                draw_q  <= 1'b1;
                out_q   <= fifo_head;
            end else begin
                if (flush || finish) owned_q <= 1'b0;
                if (finish)          draw_q  <= 1'b0;
            end
            if (wr_push && fifo_full && !fifo_pop)  ovf_q <= 1'b1;
            else if (wr_ctrl && avs_writedata[1])   ovf_q <= 1'b0;
            if (tmo_hit)                            tmo_q <= 1'b1;
            else if (wr_ctrl && avs_writedata[2])   tmo_q <= 1'b0;
            seq_idle_q <= (fifo_count == '0) && (state_q == ST_IDLE);
        end
    end

    // STATUS word assembly.
    always_comb begin
        status       = '0;
        status[7:0]  = 8'(fifo_count);
        status[8]    = fifo_full;
        status[9]    = ovf_q;
        status[10]   = tmo_q;
        status[11]   = (state_q != ST_IDLE);
    end

    // Registered read mux; unmapped and write-only offsets read as zero.
    always_ff @(posedge Clk) begin
        if (Reset || !avs_read) begin
            rdata_q <= '0;
        end else begin
            case (avs_address)
                REG_ID:     rdata_q <= {16'h0, stage_q.id};
                REG_X:      rdata_q <= {16'h0, stage_q.x};
                REG_Y:      rdata_q <= {16'h0, stage_q.y};
                REG_W:      rdata_q <= {16'h0, stage_q.w};
                REG_H:      rdata_q <= {16'h0, stage_q.h};
                REG_ADDR:   rdata_q <= stage_q.addr;
                REG_ROT:    rdata_q <= {24'h0, stage_q.rot};
                REG_STATUS: rdata_q <= status;
                default:    rdata_q <= '0;
            endcase
        end
    end

    assign avs_readdata   = rdata_q;
    assign draw_sprite    = draw_q;
    assign seq_idle       = seq_idle_q;
    assign sprite_id      = out_q.id;
    assign sprite_x       = out_q.x;
    assign sprite_y       = out_q.y;
    assign sprite_width   = out_q.w;
    assign sprite_height  = out_q.h;
    assign sprite_address = out_q.addr;
    assign sprite_rotate  = out_q.rot;

endmodule

// File: tb/tb_sprite_cmd_sequencer.sv
// Bench for sprite_cmd_sequencer: register vectors, issue scoreboard, overflow, timeout and reset sequences.
// Latency: n/a.
// Backpressure: drawer model either completes after 2+64 cycles or never accepts (hung).
`timescale 1ns/1ps
module tb_sprite_cmd_sequencer;
    import sprite_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        draw_sprite;
    logic        done_draw;
    logic [15:0] sprite_id, sprite_x, sprite_y, sprite_width, sprite_height;
    logic [31:0] sprite_address;
    logic [7:0]  sprite_rotate;
    logic        seq_idle;

    sprite_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .draw_sprite    (draw_sprite),
        .done_draw      (done_draw),
        .sprite_id      (sprite_id),
        .sprite_x       (sprite_x),
        .sprite_y       (sprite_y),
        .sprite_width   (sprite_width),
        .sprite_height  (sprite_height),
        .sprite_address (sprite_address),
        .sprite_rotate  (sprite_rotate),
        .seq_idle       (seq_idle)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    int drw_mode = 0;   // 0: normal drawer, 1: hung drawer (never lowers done_draw)

    sprite_desc_t obs;
    sprite_desc_t cur;
    sprite_desc_t exp_d;
    sprite_desc_t exp_q[$];
    logic prev_draw = 1'b0;
    logic seen_fall = 1'b0;
    logic stable_ok = 1'b1;
    int   hi_len = 0, lo_len = 0, last_hi_len = 0, n_issued = 0, n_falls = 0;

    assign obs = {sprite_id, sprite_x, sprite_y, sprite_width, sprite_height, sprite_address, sprite_rotate};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Request monitor: scoreboard on each rise, stability while high, gap between requests.
    always @(negedge Clk) begin
        if (Reset) begin
            prev_draw = 1'b0;
            seen_fall = 1'b0;
            hi_len    = 0;
            lo_len    = 0;
        end else begin
            if (draw_sprite && !prev_draw) begin
                n_issued++;
                if (seen_fall) check("req_gap_ge3", 32'(lo_len >= 3), 32'd1);
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: got desc 0x%0h, expected no request", obs);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (obs !== exp_d) begin
                        n_fail++;
                        $display("FAIL issue_desc: got 0x%0h, expected 0x%0h", obs, exp_d);
                    end
                end
                cur       = obs;
                stable_ok = 1'b1;
                hi_len    = 1;
            end else if (draw_sprite) begin
                hi_len++;
                if (obs !== cur) stable_ok = 1'b0;
            end else if (prev_draw) begin
                n_falls++;
                last_hi_len = hi_len;
                seen_fall   = 1'b1;
                lo_len      = 1;
                check("fields_stable", 32'(stable_ok), 32'd1);
            end else begin
                lo_len++;
            end
            prev_draw = draw_sprite;
        end
    end

    // Drawer model: accept 2 cycles after request, finish 64 cycles later.
    initial begin
        done_draw = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (draw_sprite && drw_mode == 0) begin
                repeat (2) @(posedge Clk);
                #1 done_draw = 1'b0;
                repeat (64) @(posedge Clk);
                #1 done_draw = 1'b1;
                while (draw_sprite) begin @(posedge Clk); #1; end
            end
        end
    end

    initial begin
        repeat (30000) @(posedge Clk);
        $display("FAIL watchdog: still running after 30000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(posedge Clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(posedge Clk); #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic push_desc(input sprite_desc_t d, input bit accept);
        bus_wr(REG_ID,   {16'hA5A5, d.id});
        bus_wr(REG_X,    {16'hA5A5, d.x});
        bus_wr(REG_Y,    {16'hA5A5, d.y});
        bus_wr(REG_W,    {16'hA5A5, d.w});
        bus_wr(REG_H,    {16'hA5A5, d.h});
        bus_wr(REG_ADDR, d.addr);
        bus_wr(REG_ROT,  {24'h5A5A5A, d.rot});
        bus_wr(REG_PUSH, 32'h0);
        if (accept) exp_q.push_back(d);
    endtask

    task automatic wait_falls(input int target, input string name);
        int budget = 600;
        while (n_falls < target && budget > 0) begin @(posedge Clk); #1; budget--; end
        check(name, 32'(n_falls), 32'(target));
    endtask

    function automatic sprite_desc_t mk(input int n);
        sprite_desc_t r;
        r.id   = 16'(16'h100 + n);
        r.x    = 16'(n * 3);
        r.y    = 16'(n * 5 + 1);
        r.w    = 16'(n + 2);
        r.h    = 16'(n + 4);
        r.addr = 32'h2000_0000 + 32'(n) * 32'h400;
        r.rot  = 8'(n);
        return r;
    endfunction

    typedef struct {
        logic        wr;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t         vt [16];
    logic [31:0]  rdat;
    sprite_desc_t d1;
    int           base, iss;

    initial begin
        vt = '{
            '{1'b0, REG_ID,     32'h0,         32'h0},
            '{1'b0, REG_ADDR,   32'h0,         32'h0},
            '{1'b1, REG_ID,     32'hDEAD_1234, 32'h0},
            '{1'b0, REG_ID,     32'h0,         32'h0000_1234},
            '{1'b1, REG_ROT,    32'hABCD_01FF, 32'h0},
            '{1'b0, REG_ROT,    32'h0,         32'h0000_00FF},
            '{1'b1, REG_ADDR,   32'hCAFE_F00D, 32'h0},
            '{1'b0, REG_ADDR,   32'h0,         32'hCAFE_F00D},
            '{1'b1, REG_H,      32'h0003_0008, 32'h0},
            '{1'b0, REG_H,      32'h0,         32'h0000_0008},
            '{1'b0, REG_PUSH,   32'h0,         32'h0},
            '{1'b0, REG_CTRL,   32'h0,         32'h0},
            '{1'b1, 4'hC,       32'hFFFF_FFFF, 32'h0},
            '{1'b0, 4'hF,       32'h0,         32'h0},
            '{1'b0, REG_STATUS, 32'h0,         32'h0},
            '{1'b0, REG_X,      32'h0,         32'h0}
        };
        Reset = 1'b1; avs_address = '0; avs_write = 1'b0; avs_writedata = '0; avs_read = 1'b0;
        repeat (3) @(posedge Clk); #1;
        Reset = 1'b0;
        check("rst_draw", 32'(draw_sprite), 32'd0);
        check("rst_seq_idle", 32'(seq_idle), 32'd1);
        check("rst_fields", 32'(|obs), 32'd0);
        bus_rd(REG_STATUS, rdat); check("rst_status", rdat, 32'h0);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) bus_wr(vt[i].a, vt[i].d);
            else begin
                bus_rd(vt[i].a, rdat);
                check($sformatf("reg_vec%0d", i), rdat, vt[i].exp);
            end
        end

        // Single sprite through the full handshake.
        d1 = '{id:16'd1, x:16'd10, y:16'd20, w:16'd8, h:16'd8, addr:32'h1000, rot:8'd0};
        base = n_falls;
        push_desc(d1, 1'b1);
        wait_falls(base + 1, "single_done");
        check("single_hi_len", 32'(last_hi_len), 32'd67);
        repeat (3) @(posedge Clk); #1;
        check("single_draw_low", 32'(draw_sprite), 32'd0);
        check("single_seq_idle", 32'(seq_idle), 32'd1);

        // Three queued sprites drain in order; count observed falling 3,2,1,0.
        base = n_falls;
        for (int i = 0; i < 3; i++) push_desc(mk(i + 1), 1'b1);
        bus_rd(REG_STATUS, rdat); check("b2b_status3", rdat, 32'h803);
        for (int k = 2; k >= 0; k--) begin
            wait_falls(base + 3 - k, $sformatf("b2b_fall%0d", 3 - k));
            bus_rd(REG_STATUS, rdat);
            check($sformatf("b2b_status%0d", k), rdat, 32'h800 | 32'(k));
        end
        repeat (4) @(posedge Clk); #1;
        bus_rd(REG_STATUS, rdat); check("b2b_status_idle", rdat, 32'h0);

        // Overflow with a hung drawer, then timeout of the in-flight entry.
        drw_mode = 1;
        base = n_falls;
        iss  = n_issued;
        for (int i = 0; i < DEPTH + 1; i++) push_desc(mk(10 + i), i < DEPTH);
        bus_rd(REG_STATUS, rdat); check("ovf_status", rdat, 32'hB04);
        bus_wr(REG_CTRL, 32'h2);
        bus_rd(REG_STATUS, rdat); check("ovf_cleared", rdat, 32'h904);
        wait_falls(base + 1, "tmo_fall");
        drw_mode = 0;
        check("tmo_hi_len", 32'(last_hi_len), 32'(TMO));
        bus_rd(REG_STATUS, rdat); check("tmo_status", rdat, 32'hC03);
        wait_falls(base + 4, "ovf_drain");
        check("drain_hi_len", 32'(last_hi_len), 32'd67);
        repeat (4) @(posedge Clk); #1;
        bus_wr(REG_CTRL, 32'h4);
        bus_rd(REG_STATUS, rdat); check("tmo_cleared", rdat, 32'h0);
        check("ovf_issue_count", 32'(n_issued - iss), 32'(DEPTH));
        check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset while busy with two more queued.
        for (int i = 0; i < 3; i++) push_desc(mk(20 + i), 1'b1);
        repeat (10) @(posedge Clk); #1;
        check("pre_reset_draw", 32'(draw_sprite), 32'd1);
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midrst_draw", 32'(draw_sprite), 32'd0);
        check("midrst_fields", 32'(|obs), 32'd0);
        check("midrst_seq_idle", 32'(seq_idle), 32'd1);
        Reset = 1'b0;
        exp_q.delete();
        bus_rd(REG_STATUS, rdat); check("midrst_status", rdat, 32'h0);
        iss = n_issued;
        repeat (150) @(posedge Clk); #1;
        check("no_issue_after_reset", 32'(n_issued - iss), 32'd0);
        check("post_reset_draw", 32'(draw_sprite), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
